alu_exec_unit: RTL and testbench

- Execution-stage ALU that consumes the 5-bit ALU control code produced by the ALU control decoder.
- Performs the operation on the register/immediate operands and returns the result together with branch-condition and overflow flags.
- Single-cycle operations finish in one registered cycle. MULT/MULTU run as an iterative 32-step shift-add engine that writes the HI/LO registers.
- Sits between the ID/EX operand muxes and the EX/MEM writeback path.

---
 rtl/alu_exec_unit_pkg.sv | 40 ++++
 rtl/alu_exec_unit_mul_shift_add.sv | 93 +++++++++
 rtl/alu_exec_unit.sv | 176 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU control codes, datapath width and exec-unit FSM encoding.
package alu_exec_unit_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [4:0] ALU_Add     = 5'd0;
    localparam logic [4:0] ALU_Addu    = 5'd1;
    localparam logic [4:0] ALU_Sub     = 5'd2;
    localparam logic [4:0] ALU_Subu    = 5'd3;
    localparam logic [4:0] ALU_And     = 5'd4;
    localparam logic [4:0] ALU_Or      = 5'd5;
    localparam logic [4:0] ALU_Xor     = 5'd6;
    localparam logic [4:0] ALU_Nor     = 5'd7;
    localparam logic [4:0] ALU_Slt     = 5'd8;
    localparam logic [4:0] ALU_Sltu    = 5'd9;
    localparam logic [4:0] ALU_Sll     = 5'd10;
    localparam logic [4:0] ALU_Srl     = 5'd11;
    localparam logic [4:0] ALU_Sra     = 5'd12;
    localparam logic [4:0] ALU_Lui     = 5'd13;
    localparam logic [4:0] ALU_Ge      = 5'd14;
    localparam logic [4:0] ALU_Le      = 5'd15;
    localparam logic [4:0] ALU_Gt      = 5'd16;
    localparam logic [4:0] ALU_Jr      = 5'd17;
    localparam logic [4:0] ALU_Jalr    = 5'd18;
    localparam logic [4:0] ALU_Mult    = 5'd19;
    localparam logic [4:0] ALU_Multu   = 5'd20;
    localparam logic [4:0] ALU_Mfhi    = 5'd21;
    localparam logic [4:0] ALU_Mflo    = 5'd22;
    localparam logic [4:0] ALU_Invalid = 5'd31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    function automatic logic is_mul_op(input logic [4:0] code);
        return (code == ALU_Mult) || (code == ALU_Multu);
    endfunction

endpackage

// File: rtl/alu_exec_unit_mul_shift_add.sv
// Iterative shift-add multiplier owning HI/LO; signed operands run on magnitudes.
// ALU_MUL_EARLY_TERM_EN: stop as soon as the remaining multiplier is exhausted.
module mul_shift_add
    import alu_exec_unit_pkg::*;
#(
    parameter int W     = 32,
    parameter int STEPS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         last,
    output logic [W-1:0] lo_next,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CNT_W = $clog2(STEPS);

    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2*W-1:0]   mcand_r;
    logic [W-1:0]     mplier_r;
    logic [2*W-1:0]   acc_r;
    logic             neg_r;
    logic [W-1:0]     hi_r;
    logic [W-1:0]     lo_r;

    logic [W-1:0]     mag_a_s;
    logic [W-1:0]     mag_b_s;
    logic [2*W-1:0]   acc_next_s;
    logic [2*W-1:0]   prod_s;
    logic             last_s;

    // Operand magnitudes, next accumulator, final signed product and finish detect.
    always_comb begin
        mag_a_s    = (is_signed && op_a[W-1]) ? ({W{1'b0}} - op_a) : op_a;
        mag_b_s    = (is_signed && op_b[W-1]) ? ({W{1'b0}} - op_b) : op_b;
        acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {(2*W){1'b0}});
        prod_s     = neg_r ? ({(2*W){1'b0}} - acc_next_s) : acc_next_s;
`ifdef ALU_MUL_EARLY_TERM_EN
        last_s     = busy_r && ((cnt_r == CNT_W'(STEPS-1)) || (mplier_r[W-1:1] == {(W-1){1'b0}}));
`else
        last_s     = busy_r && (cnt_r == CNT_W'(STEPS-1));
`endif
    end

    // Engine state: latch on start, one shift-add step per cycle, commit HI/LO on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            cnt_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            neg_r    <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_W'(1);
            if (last_s) begin
                busy_r <= 1'b0;
                hi_r   <= prod_s[2*W-1:W];
                lo_r   <= prod_s[W-1:0];
            end else begin
                busy_r <= 1'b1;
            end
        end else if (start) begin
            busy_r   <= 1'b1;
            cnt_r    <= '0;
            mcand_r  <= {{W{1'b0}}, mag_a_s};
            mplier_r <= mag_b_s;
            acc_r    <= '0;
            neg_r    <= is_signed && (op_a[W-1] ^ op_b[W-1]);
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign last    = last_s;
    assign lo_next = prod_s[W-1:0];
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle ops with registered result/flags, MULT/MULTU via mul_shift_add.
// ALU_MUL_EARLY_TERM_EN (in mul_shift_add) shortens multiplies with small multipliers.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cond,
    output logic             ovf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    alu_state_e       state_r, state_next_s;
    logic             in_ready_r;
    logic             out_valid_r, zero_r, cond_r, ovf_r;
    logic [WIDTH-1:0] result_r;

    logic             accept_s, mul_start_s, mul_last_s, mul_busy_s;
    logic [WIDTH-1:0] mul_lo_next_s;
    logic [WIDTH-1:0] sum_s, diff_s, res_s;
    logic             cond_s, ovf_s;

    assign sum_s  = src_a + src_b;
    assign diff_s = src_a - src_b;

    // Single-cycle datapath: result, condition and signed-overflow for the presented code.
    always_comb begin
        res_s  = '0;
        cond_s = 1'b0;
        ovf_s  = 1'b0;
        case (alu_ctrl)
            ALU_Add:  begin
                res_s = sum_s;
                ovf_s = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_Addu: res_s = sum_s;
            ALU_Sub:  begin
                res_s = diff_s;
                ovf_s = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff_s[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_Subu: res_s = diff_s;
            ALU_And:  res_s = src_a & src_b;
            ALU_Or:   res_s = src_a | src_b;
            ALU_Xor:  res_s = src_a ^ src_b;
            ALU_Nor:  res_s = ~(src_a | src_b);
            ALU_Slt:  begin
                cond_s = $signed(src_a) < $signed(src_b);
                res_s  = {{(WIDTH-1){1'b0}}, cond_s};
            end
            ALU_Sltu: begin
                cond_s = src_a < src_b;
                res_s  = {{(WIDTH-1){1'b0}}, cond_s};
            end
            ALU_Sll:  res_s = src_b << shamt;
            ALU_Srl:  res_s = src_b >> shamt;
            ALU_Sra:  res_s = $signed(src_b) >>> shamt;
            ALU_Lui:  res_s = {src_b[15:0], 16'h0000};
            ALU_Ge:   begin
                cond_s = ~src_a[WIDTH-1];
                res_s  = {{(WIDTH-1){1'b0}}, cond_s};
            end
            ALU_Le:   begin
                cond_s = src_a[WIDTH-1] | (src_a == '0);
                res_s  = {{(WIDTH-1){1'b0}}, cond_s};
            end
            ALU_Gt:   begin
                cond_s = ~src_a[WIDTH-1] & (src_a != '0);
                res_s  = {{(WIDTH-1){1'b0}}, cond_s};
            end
            ALU_Jr, ALU_Jalr: begin
                res_s  = src_a;
                cond_s = 1'b1;
            end
            ALU_Mfhi: res_s = hi;
            ALU_Mflo: res_s = lo;
            default:  res_s = '0;
        endcase
    end

    // Next-state logic: IDLE accepts every cycle, MUL holds off input until the engine finishes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        mul_start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = in_valid;
                if (in_valid && is_mul_op(alu_ctrl)) begin
                    mul_start_s  = 1'b1;
                    state_next_s = ST_MUL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered outputs; a multiply completion reports the new LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            cond_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= (state_next_s == ST_IDLE);
            if (accept_s && !mul_start_s) begin
                out_valid_r <= 1'b1;
                result_r    <= res_s;
                zero_r      <= (res_s == '0);
                cond_r      <= cond_s;
                ovf_r       <= ovf_s;
            end else if (mul_last_s) begin
                out_valid_r <= 1'b1;
                result_r    <= mul_lo_next_s;
                zero_r      <= (mul_lo_next_s == '0);
                cond_r      <= 1'b0;
                ovf_r       <= 1'b0;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    mul_shift_add #(
        .W     (WIDTH),
        .STEPS (MUL_STEPS)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start_s),
        .is_signed (alu_ctrl == ALU_Mult),
        .op_a      (src_a),
        .op_b      (src_b),
        .busy      (mul_busy_s),
        .last      (mul_last_s),
        .lo_next   (mul_lo_next_s),
        .hi        (hi),
        .lo        (lo)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign cond      = cond_r;
    assign ovf       = ovf_r;
    assign busy      = mul_busy_s;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: arithmetic reference model plus directed literal checks.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [4:0]  alu_ctrl = 5'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        in_ready, out_valid, zero, cond, ovf, busy;
    logic [31:0] result, hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .shamt(shamt),
        .out_valid(out_valid), .result(result), .zero(zero), .cond(cond),
        .ovf(ovf), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic        cd;
        logic        ov;
    } exp_t;

    function automatic exp_t ref_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, input logic [31:0] h, input logic [31:0] l);
        exp_t   e;
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (c)
            ALU_Add:  begin t = sa + sb; e.res = a + b; e.ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            ALU_Sub:  begin t = sa - sb; e.res = a - b; e.ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            ALU_Addu: e.res = a + b;
            ALU_Subu: e.res = a - b;
            ALU_And:  e.res = a & b;
            ALU_Or:   e.res = a | b;
            ALU_Xor:  e.res = a ^ b;
            ALU_Nor:  e.res = ~(a | b);
            ALU_Slt:  begin e.cd = sa < sb; e.res = {31'd0, e.cd}; end
            ALU_Sltu: begin e.cd = a < b;   e.res = {31'd0, e.cd}; end
            ALU_Sll:  e.res = b << sh;
            ALU_Srl:  e.res = b >> sh;
            ALU_Sra:  e.res = 32'(sb >>> sh);
            ALU_Lui:  e.res = b * 32'd65536;
            ALU_Ge:   begin e.cd = sa >= 64'sd0; e.res = {31'd0, e.cd}; end
            ALU_Le:   begin e.cd = sa <= 64'sd0; e.res = {31'd0, e.cd}; end
            ALU_Gt:   begin e.cd = sa > 64'sd0;  e.res = {31'd0, e.cd}; end
            ALU_Jr, ALU_Jalr: begin e.res = a; e.cd = 1'b1; end
            ALU_Mfhi: e.res = h;
            ALU_Mflo: e.res = l;
            default:  e = '0;
        endcase
        return e;
    endfunction

    function automatic logic [63:0] ref_prod(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (c == ALU_Mult) return 64'(longint'($signed(a)) * longint'($signed(b)));
        else               return ua * ub;
    endfunction

    function automatic int ref_mul_cycles(input logic [31:0] b, input logic is_s);
`ifdef ALU_MUL_EARLY_TERM_EN
        logic [31:0] mb;
        int          top;
        mb  = (is_s && b[31]) ? (32'd0 - b) : b;
        top = 0;
        for (int i = 0; i < 32; i++) if (mb[i]) top = i;
        return top + 1;
`else
        return (b == 32'd0 && is_s) ? 32 : 32;
`endif
    endfunction

    // Reference model state.
    logic        m_init = 1'b0;
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [63:0] m_prod = 64'd0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic        e_valid = 1'b0;
    exp_t        e_exp = '0;

    // Cycle-level reference: accepts when idle, counts multiply cycles, pulses expected results.
    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_busy  <= 1'b0;
            m_left  <= 0;
            m_hi    <= 32'd0;
            m_lo    <= 32'd0;
            e_valid <= 1'b0;
            e_exp   <= '0;
        end else begin
            e_valid <= 1'b0;
            if (m_busy) begin
                if (m_left <= 1) begin
                    m_busy  <= 1'b0;
                    m_hi    <= m_prod[63:32];
                    m_lo    <= m_prod[31:0];
                    e_valid <= 1'b1;
                    e_exp   <= '{res: m_prod[31:0], cd: 1'b0, ov: 1'b0};
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (in_valid) begin
                if (alu_ctrl == ALU_Mult || alu_ctrl == ALU_Multu) begin
                    m_busy <= 1'b1;
                    m_left <= ref_mul_cycles(src_b, alu_ctrl == ALU_Mult);
                    m_prod <= ref_prod(alu_ctrl, src_a, src_b);
                end else begin
                    e_valid <= 1'b1;
                    e_exp   <= ref_op(alu_ctrl, src_a, src_b, shamt, m_hi, m_lo);
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (m_init) begin
            check("out_valid", out_valid, e_valid);
            check("in_ready", in_ready, !m_busy);
            check("busy", busy, m_busy);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            if (e_valid) begin
                check("result", result, e_exp.res);
                check("zero", zero, e_exp.res == 32'd0);
                check("cond", cond, e_exp.cd);
                check("ovf", ovf, e_exp.ov);
            end
        end
    end

    task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        alu_ctrl = c; src_a = a; src_b = b; shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_mul(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, output int lat);
        int n;
        issue(c, a, b, 5'd0);
        check("mul_in_ready_low", in_ready, 1'b0);
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("mul_done_in_time", out_valid, 1'b1);
        lat = n;
    endtask

    logic [4:0]  t_c [18] = '{ALU_And, ALU_Or, ALU_Xor, ALU_Nor, ALU_Sltu, ALU_Sll, ALU_Srl, ALU_Ge,
                              ALU_Le, ALU_Gt, ALU_Gt, ALU_Le, ALU_Jr, ALU_Jalr, ALU_Sub, ALU_Subu,
                              ALU_Invalid, 5'd30};
    logic [31:0] t_a [18] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF,
                              32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'h80000000, 32'hDEADBEEF,
                              32'h00400000, 32'h80000000, 32'd0, 32'h12345678, 32'h12345678};
    logic [31:0] t_b [18] = '{32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'd1,
                              32'd1, 32'h80000000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'd0, 32'd1, 32'd1, 32'h1, 32'h1};
    logic [4:0]  t_s [18] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0,
                              5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {zero, cond, ovf}, 3'b000);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ready", {in_ready, busy}, 2'b10);
        rst = 1'b0;

        issue(ALU_Add, 32'h7FFFFFFF, 32'd1, 5'd0);
        check("add_valid", out_valid, 1'b1);
        check("add_result", result, 32'h80000000);
        check("add_ovf_zero", {ovf, zero}, 2'b10);

        issue(ALU_Subu, 32'd5, 32'd5, 5'd0);
        check("subu_result", {result, zero}, {32'd0, 1'b1});
        issue(ALU_Slt, 32'hFFFFFFFF, 32'd1, 5'd0);
        check("slt_result", {out_valid, result, cond}, {1'b1, 32'd1, 1'b1});

        issue(ALU_Sra, 32'd0, 32'h80000000, 5'd4);
        check("sra_result", result, 32'hF8000000);
        issue(ALU_Lui, 32'd0, 32'h00001234, 5'd0);
        check("lui_result", result, 32'h12340000);

        for (int i = 0; i < 18; i++) issue(t_c[i], t_a[i], t_b[i], t_s[i]);
        @(posedge clk); #1;

        run_mul(ALU_Mult, 32'hFFFFFFFB, 32'd0, lat);
        check("mul0_hilo", {hi, lo}, 64'd0);
        check("mul0_zero", zero, 1'b1);
`ifdef ALU_MUL_EARLY_TERM_EN
        check("mul0_latency", lat, 2);
`else
        check("mul0_latency", lat, 33);
`endif

        run_mul(ALU_Mult, 32'h80000000, 32'h80000000, lat);
        check("mulmin_hilo", {hi, lo}, 64'h4000000000000000);

        run_mul(ALU_Mult, 32'hFFFFFFFD, 32'd7, lat);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", {lo, result}, {32'hFFFFFFEB, 32'hFFFFFFEB});
`ifdef ALU_MUL_EARLY_TERM_EN
        check("mult_latency", lat, 4);
`else
        check("mult_latency", lat, 33);
`endif
        issue(ALU_Mfhi, 32'd0, 32'd0, 5'd0);
        check("mfhi_result", result, 32'hFFFFFFFF);

        // Competing request held high while the multiply runs.
        alu_ctrl = ALU_Multu; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        alu_ctrl = ALU_Addu; src_a = 32'd1; src_b = 32'd2;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE00000001);
        check("multu_result", result, 32'h00000001);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("held_op_result", {out_valid, result}, {1'b1, 32'd3});
        issue(ALU_Mflo, 32'd0, 32'd0, 5'd0);
        check("mflo_result", result, 32'h00000001);

        // Reset in the middle of a multiply.
        issue(ALU_Mult, 32'd9, 32'h40000000, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", {out_valid, in_ready, busy}, 3'b010);
        check("abort_hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) check("abort_no_valid", out_valid, 1'b0);
        end
        issue(ALU_Mfhi, 32'd0, 32'd0, 5'd0);
        check("abort_mfhi", {out_valid, result}, {1'b1, 32'd0});
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
